// File: rtl/imm_encoder.sv
// RV32I immediate-instruction encoder: turns a decoded request into a 32-bit word
// tagged with its instruction-memory address, behind a one-deep valid/ready output stage.
module imm_encoder #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_kind,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  input  logic        addr_load,
  input  logic [31:0] addr_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {IDLE, FULL, ERR} state_t;

  localparam logic [3:0] K_LOAD = 4'd0, K_STORE = 4'd1, K_BRANCH = 4'd2,
                         K_ADDI = 4'd3, K_SLTI  = 4'd4, K_SLTIU  = 4'd5,
                         K_XORI = 4'd6, K_ORI   = 4'd7, K_ANDI   = 4'd8,
                         K_SLLI = 4'd9, K_SRLI  = 4'd10, K_SRAI  = 4'd11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ALU    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t      state, state_nxt;
  logic [31:0] cnt;
  logic [31:0] word;
  logic [31:0] base;
  logic [2:0]  alu_f3;
  logic        legal, accept;
  logic        fits12, fits_shamt, fits_branch;

  // Range checks as sign-extension tests on the upper immediate bits.
  assign fits12      = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits_shamt  = ~(|in_imm[31:5]);
  assign fits_branch = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    alu_f3 = 3'b000;
    case (in_kind)
      K_SLTI:  alu_f3 = 3'b010;
      K_SLTIU: alu_f3 = 3'b011;
      K_XORI:  alu_f3 = 3'b100;
      K_ORI:   alu_f3 = 3'b110;
      K_ANDI:  alu_f3 = 3'b111;
      default: alu_f3 = 3'b000;
    endcase
  end

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (in_kind)
      K_LOAD: begin
        legal = fits12 && (in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
      end
      K_STORE: begin
        legal = fits12 && (in_funct3 inside {3'b000, 3'b001, 3'b010});
        word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
      end
      K_BRANCH: begin
        legal = fits_branch && !(in_funct3 inside {3'b010, 3'b011});
        word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                 in_imm[4:1], in_imm[11], OP_BRANCH};
      end
      K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI: begin
        legal = fits12;
        word  = {in_imm[11:0], in_rs1, alu_f3, in_rd, OP_ALU};
      end
      K_SLLI: begin
        legal = fits_shamt;
        word  = {7'b0000000, in_imm[4:0], in_rs1, 3'b001, in_rd, OP_ALU};
      end
      K_SRLI: begin
        legal = fits_shamt;
        word  = {7'b0000000, in_imm[4:0], in_rs1, 3'b101, in_rd, OP_ALU};
      end
      K_SRAI: begin
        legal = fits_shamt;
        word  = {7'b0100000, in_imm[4:0], in_rs1, 3'b101, in_rd, OP_ALU};
      end
      default: begin
        legal = 1'b0;
        word  = '0;
      end
    endcase
  end

  always_comb begin
    case (state)
      IDLE:    in_ready = 1'b1;
      FULL:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign out_valid = (state == FULL);
  assign err       = (state == ERR);
  assign base      = addr_load ? addr_in : cnt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FULL: begin
        if (accept)                 state_nxt = legal ? FULL : ERR;
        else if (state == FULL && out_ready) state_nxt = IDLE;
      end
      ERR:     if (err_clr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state and registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_instr <= '0;
      out_addr  <= '0;
      cnt       <= RESET_ADDR;
    end else if (accept && legal) begin
      out_instr <= word;
      out_addr  <= base;
      cnt       <= base + 32'd4;
    end else if (addr_load && !accept) begin
      // An illegal accept leaves the counter alone even if addr_load is set.
      cnt <= addr_in;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: a cycle-level reference model compared every
// cycle, plus directed vectors with hand-computed encodings.
module tb_imm_encoder;

  localparam logic [31:0] RST_A = 32'h0000_1000;

  logic        clk, reset;
  logic        in_valid, in_ready;
  logic [3:0]  in_kind;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        addr_load;
  logic [31:0] addr_in;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_addr;
  logic        err, err_clr;

  int checks = 0;
  int errors = 0;

  imm_encoder #(.RESET_ADDR(RST_A)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_funct3(in_funct3),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .addr_load(addr_load), .addr_in(addr_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder from the instruction-format rules, in plain integer arithmetic.
  function automatic bit ref_encode(input int kind, input int f3, input int rd, input int rs1,
                                    input int rs2, input int imm, output logic [31:0] w);
    bit ok;
    int v, af3;
    ok = 0;
    v  = 0;
    if (kind == 0) begin
      ok = imm >= -2048 && imm <= 2047 && (f3 inside {0, 1, 2, 4, 5});
      v  = ((imm & 'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h03;
    end else if (kind == 1) begin
      ok = imm >= -2048 && imm <= 2047 && (f3 inside {0, 1, 2});
      v  = (((imm >> 5) & 'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
         | ((imm & 'h1f) << 7) | 'h23;
    end else if (kind == 2) begin
      ok = imm >= -4096 && imm <= 4094 && (imm % 2 == 0) && !(f3 inside {2, 3});
      v  = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3f) << 25) | (rs2 << 20)
         | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 'hf) << 8) | (((imm >> 11) & 1) << 7) | 'h63;
    end else if (kind >= 3 && kind <= 8) begin
      case (kind)
        3: af3 = 0; 4: af3 = 2; 5: af3 = 3; 6: af3 = 4; 7: af3 = 6;
        default: af3 = 7;
      endcase
      ok = imm >= -2048 && imm <= 2047;
      v  = ((imm & 'hfff) << 20) | (rs1 << 15) | (af3 << 12) | (rd << 7) | 'h13;
    end else if (kind >= 9 && kind <= 11) begin
      ok = imm >= 0 && imm <= 31;
      v  = ((kind == 11 ? 'h20 : 0) << 25) | ((imm & 'h1f) << 20) | (rs1 << 15)
         | ((kind == 9 ? 1 : 5) << 12) | (rd << 7) | 'h13;
    end
    w = v;
    return ok;
  endfunction

  // Cycle-level model: one output slot, sticky error, address counter.
  logic        m_valid, m_err;
  logic [31:0] m_instr, m_addr, m_cnt;
  logic [31:0] ref_w, ref_base;
  bit          ref_ok;
  logic        m_rdy, m_acc;

  always_comb begin
    ref_w  = '0;
    ref_ok = ref_encode(int'(in_kind), int'(in_funct3), int'(in_rd), int'(in_rs1),
                        int'(in_rs2), int'($signed(in_imm)), ref_w);
  end

  assign m_rdy    = m_err ? 1'b0 : (m_valid ? out_ready : 1'b1);
  assign m_acc    = in_valid && m_rdy;
  assign ref_base = addr_load ? addr_in : m_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_err   <= 1'b0;
      m_instr <= '0;
      m_addr  <= '0;
      m_cnt   <= RST_A;
    end else if (m_acc && ref_ok) begin
      m_instr <= ref_w;
      m_addr  <= ref_base;
      m_cnt   <= ref_base + 32'd4;
      m_valid <= 1'b1;
    end else if (m_acc) begin
      m_err   <= 1'b1;
      m_valid <= 1'b0;
    end else begin
      if (out_ready)          m_valid <= 1'b0;
      if (m_err && err_clr)   m_err   <= 1'b0;
      if (addr_load)          m_cnt   <= addr_in;
    end
  end

  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'(m_rdy));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("err", 32'(err), 32'(m_err));
    if (m_valid) begin
      check("out_instr", out_instr, m_instr);
      check("out_addr", out_addr, m_addr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int kind, input int f3, input int rd, input int rs1,
                     input int rs2, input int imm);
    in_kind   = 4'(kind);
    in_funct3 = 3'(f3);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_imm    = 32'(imm);
    in_valid  = 1'b1;
  endtask

  task automatic run_vec(input int kind, input int f3, input int rd, input int rs1,
                         input int rs2, input int imm, input bit legal, input logic [31:0] w);
    out_ready = 1'b1;
    req(kind, f3, rd, rs1, rs2, imm);
    step();
    in_valid = 1'b0;
    if (legal) begin
      check("vec_valid", 32'(out_valid), 32'd1);
      check("vec_instr", out_instr, w);
    end else begin
      check("vec_err", 32'(err), 32'd1);
      check("vec_novalid", 32'(out_valid), 32'd0);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_kind = '0; in_funct3 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    addr_load = 1'b0; addr_in = '0; out_ready = 1'b0; err_clr = 1'b0;
    step(); step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_addr", out_addr, 32'h0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    // Plain counter load with no request, so the first word lands at 0.
    addr_load = 1'b1; addr_in = 32'h0;
    step();
    addr_load = 1'b0;

    // ADDI x1, x0, -1
    out_ready = 1'b1;
    req(3, 0, 1, 0, 0, -1);
    step();
    in_valid = 1'b0;
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_instr", out_instr, 32'hFFF0_0093);
    check("addi_addr", out_addr, 32'h0);
    step();

    // SW then BEQ back-to-back, no bubble
    req(1, 2, 0, 3, 2, 8);
    addr_load = 1'b1; addr_in = 32'h0;
    step();
    addr_load = 1'b0;
    check("sw_instr", out_instr, 32'h0021_A423);
    check("sw_addr", out_addr, 32'h0);
    req(2, 0, 0, 1, 2, -4);
    step();
    in_valid = 1'b0;
    check("beq_valid", 32'(out_valid), 32'd1);
    check("beq_instr", out_instr, 32'hFE20_8EE3);
    check("beq_addr", out_addr, 32'h4);
    step();
    check("drain_valid", 32'(out_valid), 32'd0);

    // SRAI held under back-pressure while another request waits
    out_ready = 1'b0;
    req(11, 0, 5, 6, 0, 3);
    step();
    req(3, 0, 7, 7, 0, 1);
    for (int i = 0; i < 3; i++) begin
      check("srai_instr", out_instr, 32'h4033_5293);
      check("srai_addr", out_addr, 32'h8);
      check("srai_ready", 32'(in_ready), 32'd0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("srai_done", 32'(out_valid), 32'd0);

    // Illegal immediate, then legal requests ignored until err_clr
    req(3, 0, 1, 1, 0, 2048);
    step();
    check("ill_err", 32'(err), 32'd1);
    check("ill_valid", 32'(out_valid), 32'd0);
    check("ill_ready", 32'(in_ready), 32'd0);
    req(3, 0, 2, 1, 0, 5);
    step(); step();
    check("ill_hold", 32'(err), 32'd1);
    in_valid = 1'b0;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_err", 32'(err), 32'd0);
    req(3, 0, 2, 1, 0, 5);
    step();
    in_valid = 1'b0;
    check("after_instr", out_instr, 32'h0050_8113);
    check("after_addr", out_addr, 32'hC);
    step();
    req(2, 0, 0, 1, 2, 3);
    step();
    in_valid = 1'b0;
    check("br_odd_err", 32'(err), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // Illegal request arriving while a word is being delivered
    req(3, 0, 1, 0, 0, 1);
    step();
    req(12, 0, 1, 0, 0, 0);
    step();
    in_valid = 1'b0;
    check("ill_full_valid", 32'(out_valid), 32'd0);
    check("ill_full_err", 32'(err), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // Directed encodings and boundaries
    run_vec(0, 2, 5, 10, 0, -2048, 1'b1, 32'h8005_2283);
    run_vec(5, 0, 1, 2, 0, 2047, 1'b1, 32'h7FF1_3093);
    run_vec(8, 0, 31, 31, 0, 255, 1'b1, 32'h0FFF_FF93);
    run_vec(9, 6, 3, 4, 7, 31, 1'b1, 32'h01F2_1193);
    run_vec(2, 5, 0, 1, 2, 4094, 1'b1, 32'h7E20_DFE3);
    run_vec(2, 4, 0, 0, 0, -4096, 1'b1, 32'h8000_4063);
    run_vec(1, 0, 9, 1, 2, -1, 1'b1, 32'hFE20_8FA3);
    run_vec(0, 3, 1, 1, 0, 0, 1'b0, 32'h0);
    run_vec(1, 4, 0, 1, 2, 0, 1'b0, 32'h0);
    run_vec(9, 1, 1, 1, 0, 32, 1'b0, 32'h0);
    run_vec(2, 2, 0, 1, 2, 8, 1'b0, 32'h0);
    run_vec(2, 0, 0, 1, 2, 4096, 1'b0, 32'h0);
    run_vec(13, 0, 1, 1, 1, 0, 1'b0, 32'h0);
    run_vec(5, 0, 1, 1, 0, -2049, 1'b0, 32'h0);
    run_vec(11, 0, 1, 1, 0, -1, 1'b0, 32'h0);
    run_vec(1, 0, 0, 1, 2, 2048, 1'b0, 32'h0);

    // addr_load coinciding with accept, then reset mid-transfer
    out_ready = 1'b1;
    req(3, 0, 1, 0, 0, 0);
    addr_load = 1'b1; addr_in = 32'h100;
    step();
    addr_load = 1'b0;
    check("ld_addr", out_addr, 32'h100);
    req(3, 0, 1, 0, 0, 1);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("ld_next_addr", out_addr, 32'h104);
    check("ld_next_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_addr", out_addr, 32'h0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    req(3, 0, 1, 0, 0, 0);
    step();
    in_valid = 1'b0;
    check("post_rst_addr", out_addr, RST_A);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
